// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - clocked req/done control sequencer for the processor datapath
//
// Purpose:
//   Steps each instruction through FETCH, READ, EXEC, WB1, WB2 and NEXT using
//   req/done handshakes. The block owns the program counter, the latched
//   instruction word and a retired-instruction counter. A per-stage watchdog
//   sends the FSM to a sticky ERROR state if a done never arrives.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 level; begins execution at pc 0 when idle
//   fetch_req/fetch_done  instruction memory handshake; instr_in is the word
//   read_req/read_done    operand read handshake
//   alu_req/alu_done      ALU handshake
//   wr1_req/wr1_done      write-back of result 1 (address instr[20:17])
//   wr2_req/wr2_done      write-back of result 2 (address instr[16:13])
//   pc, instr             program counter and latched instruction word
//   busy, halted, error   status flags
//   retired               completed-instruction count (wraps)

module instr_sequencer #(
  parameter int INS_SIZE  = 32,
  parameter int COUNTSIZE = 8,
  parameter int TIMEOUT   = 16,
  parameter int RET_SIZE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 fetch_req,
  input  logic                 fetch_done,
  input  logic [INS_SIZE-1:0]  instr_in,
  output logic                 read_req,
  input  logic                 read_done,
  output logic                 alu_req,
  input  logic                 alu_done,
  output logic                 wr1_req,
  input  logic                 wr1_done,
  output logic                 wr2_req,
  input  logic                 wr2_done,
  output logic [COUNTSIZE-1:0] pc,
  output logic [INS_SIZE-1:0]  instr,
  output logic                 busy,
  output logic                 halted,
  output logic                 error,
  output logic [RET_SIZE-1:0]  retired
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_READ,
    S_EXEC,
    S_WB1,
    S_WB2,
    S_NEXT,
    S_HALT,
    S_ERROR
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [COUNTSIZE-1:0] pc_q, pc_d;
  logic [INS_SIZE-1:0]  instr_q, instr_d;
  logic [RET_SIZE-1:0]  retired_q, retired_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 fetch_req_q, fetch_req_d;
  logic                 read_req_q, read_req_d;
  logic                 alu_req_q, alu_req_d;
  logic                 wr1_req_q, wr1_req_d;
  logic                 wr2_req_q, wr2_req_d;
  logic                 busy_q, busy_d;
  logic                 halted_q, halted_d;
  logic                 error_q, error_d;

  logic                 in_stage;
  logic                 stage_done;
  logic [COUNTSIZE-1:0] pc_inc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    retired_d  = retired_q;
    wd_d       = wd_q;
    in_stage   = 1'b0;
    stage_done = 1'b0;
    pc_inc     = pc_q + COUNTSIZE'(1);

    // Only the done belonging to the current stage is observed.
    case (state_q)
      S_FETCH: begin in_stage = 1'b1; stage_done = fetch_done; end
      S_READ:  begin in_stage = 1'b1; stage_done = read_done;  end
      S_EXEC:  begin in_stage = 1'b1; stage_done = alu_done;   end
      S_WB1:   begin in_stage = 1'b1; stage_done = wr1_done;   end
      S_WB2:   begin in_stage = 1'b1; stage_done = wr2_done;   end
      default: begin in_stage = 1'b0; stage_done = 1'b0;       end
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_done) begin
          instr_d = instr_in;
          // Opcode 000 is a NOP: skip the datapath stages entirely.
          state_d = (instr_in[31:29] == 3'b000) ? S_NEXT : S_READ;
        end
      end
      S_READ: if (read_done) state_d = S_EXEC;
      S_EXEC: if (alu_done)  state_d = S_WB1;
      S_WB1:  if (wr1_done)  state_d = S_WB2;
      S_WB2:  if (wr2_done)  state_d = S_NEXT;
      S_NEXT: begin
        retired_d = retired_q + RET_SIZE'(1);
        state_d   = S_FETCH;
        case (instr_q[12:11])
          2'b00: pc_d = pc_inc;
          2'b01: pc_d = instr_q[10] ? pc_inc + COUNTSIZE'(instr_q[9:7]) : pc_inc;
          2'b10: pc_d = instr_q[6] ? COUNTSIZE'(instr_q[5:0]) : pc_inc;
          default: state_d = S_HALT;
        endcase
      end
      default: ;  // HALT and ERROR hold until reset
    endcase

    // A done on the same edge as the limit compare wins, because the
    // watchdog is only consulted while the stage's done is low.
    if (in_stage && !stage_done) begin
      if (wd_q == WD_LIMIT) state_d = S_ERROR;
      else                  wd_d    = wd_q + WD_W'(1);
    end

    if (state_d != state_q) wd_d = '0;

    fetch_req_d = (state_d == S_FETCH);
    read_req_d  = (state_d == S_READ);
    alu_req_d   = (state_d == S_EXEC);
    wr1_req_d   = (state_d == S_WB1);
    wr2_req_d   = (state_d == S_WB2);
    halted_d    = (state_d == S_HALT);
    error_d     = (state_d == S_ERROR);
    busy_d      = !((state_d == S_IDLE) || (state_d == S_HALT) || (state_d == S_ERROR));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      retired_q   <= '0;
      wd_q        <= '0;
      fetch_req_q <= 1'b0;
      read_req_q  <= 1'b0;
      alu_req_q   <= 1'b0;
      wr1_req_q   <= 1'b0;
      wr2_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      retired_q   <= retired_d;
      wd_q        <= wd_d;
      fetch_req_q <= fetch_req_d;
      read_req_q  <= read_req_d;
      alu_req_q   <= alu_req_d;
      wr1_req_q   <= wr1_req_d;
      wr2_req_q   <= wr2_req_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      error_q     <= error_d;
    end
  end

  assign fetch_req = fetch_req_q;
  assign read_req  = read_req_q;
  assign alu_req   = alu_req_q;
  assign wr1_req   = wr1_req_q;
  assign wr2_req   = wr2_req_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign retired   = retired_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign error     = error_q;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Clocked control FSM that sequences the processor datapath (instruction fetch, operand read, ALU, two memory write-backs, next-PC select) using explicit req/done handshakes, replacing the combinational done-chaining.
- Owns the program counter and the latched instruction word, and exposes the decoded fields to the datapath.
- Includes a per-stage watchdog and a retired-instruction counter.

Parameters:
- INS_SIZE, 32, instruction width in bits (field layout below assumes 32).
- COUNTSIZE, 8, program counter width; the PC wraps modulo 2^COUNTSIZE.
- TIMEOUT, 16, maximum cycles any stage may wait for its done before error.
- RET_SIZE, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level; sampled in IDLE to begin execution at PC 0.
- fetch_req  output  1  request to instruction memory for address pc.
- fetch_done  input  1  instruction valid on instr_in.
- instr_in  input  INS_SIZE  instruction word from instruction memory.
- read_req  output  1  operand memory read request.
- read_done  input  1  operands ready.
- alu_req  output  1  ALU start.
- alu_done  input  1  ALU results ready.
- wr1_req  output  1  write of ALU result 1 to the address in instr[20:17].
- wr1_done  input  1  write 1 complete.
- wr2_req  output  1  write of ALU result 2 to the address in instr[16:13].
- wr2_done  input  1  write 2 complete.
- pc  output  COUNTSIZE  current program counter.
- instr  output  INS_SIZE  latched instruction (fields drive the datapath).
- busy  output  1  high in every state except IDLE, HALT and ERROR.
- halted  output  1  high in HALT.
- error  output  1  high in ERROR.
- retired  output  RET_SIZE  count of completed instructions; wraps.

Behaviour:
- Reset: state=IDLE; pc=0; instr=0; retired=0; all req=0; busy=halted=error=0; watchdog=0. Reset applies in any state, including mid-handshake.
- States: IDLE, FETCH, READ, EXEC, WB1, WB2, NEXT, HALT, ERROR.
- Handshake: a stage's req is high for the whole time the FSM is in that stage's state. When done is sampled high on a clock edge, the FSM leaves the state and req is low the following cycle. A done that is already high on the first cycle of req counts. Done inputs are ignored outside their own state.
- IDLE: if start=1, go to FETCH.
- FETCH: on fetch_done, latch instr<=instr_in. If instr_in[31:29]==3'b000 (NOP), go to NEXT; otherwise go to READ.
- READ -> EXEC -> WB1 -> WB2 -> NEXT, each transition on its own done.
- NEXT is a single cycle. Using c=instr[12:11]:
  - c=00: pc<=pc+1.
  - c=01: pc<=pc+1+instr[9:7] if instr[10]=1, else pc+1.
  - c=10: pc<=zero-extended instr[5:0] if instr[6]=1, else pc+1.
  - c=11: pc is unchanged and the FSM goes to HALT.
  - In every case retired<=retired+1.
  - For c≠11 the FSM goes to FETCH.
- PC arithmetic is modulo 2^COUNTSIZE (pc=255 with +1 gives 0). retired wraps silently.
- Watchdog: cleared on every state change. Increments each cycle in FETCH, READ, EXEC, WB1 and WB2 while done is low. If it reaches TIMEOUT-1 with done still low, the FSM goes to ERROR and the instruction does not retire. If done arrives on the same edge as the TIMEOUT-1 comparison, done wins.
- HALT and ERROR are sticky; only reset exits them. start is ignored in both.
- Minimum latency per non-NOP instruction is 6 cycles (all dones immediate). A NOP takes 2 cycles.

Test Plan:
- Reset mid-EXEC with alu_req=1 -> next cycle state=IDLE, pc=0, all req=0, retired=0.
- Straight-line program of 3 ALU instructions (c=00) with done returned 1 cycle after req, followed by c=11 -> pc sequence 0,1,2, halted=1 at pc=3, retired=4.
- Instruction at pc=5 with c=01, instr[10]=1, instr[9:7]=3 -> next pc=9. Same instruction with instr[10]=0 -> next pc=6.
- Instruction at pc=2 with c=10, instr[6]=1, instr[5:0]=6'h2A -> next pc=42. pc=255 with c=00 -> next pc=0.
- NOP (instr[31:29]=0) -> read_req, alu_req, wr1_req and wr2_req never assert; pc advances and retired increments 2 cycles after FETCH entry.
- alu_done held low -> error=1 exactly TIMEOUT cycles after EXEC entry, alu_req=0, retired unchanged. start pulses afterwards have no effect until reset.
